// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file widths and the hard-wired zero register index.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order queue of pending LSU writeback results {rd, data}.
module wb_fifo import rv_pkg::*; #(
    parameter int XLEN = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [REG_ADDR_W-1:0]        push_rd,
    input  logic [XLEN-1:0]              push_data,
    input  logic                         pop,
    output logic [REG_ADDR_W-1:0]        head_rd,
    output logic [XLEN-1:0]              head_data,
    output logic [AW:0]                  count,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH*REG_ADDR_W-1:0]  ent_rd
);
    logic [REG_ADDR_W-1:0] rd_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [DEPTH-1:0] valid_nxt;

    assign head_rd = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

    // Per-entry valid bits let the hazard compare ignore stale slots.
    always_comb begin
        valid_nxt = ent_valid;
        if (pop) valid_nxt[rd_ptr] = 1'b0;
        if (push) valid_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            ent_valid <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            ent_valid <= valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr] <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
        assign ent_rd[g*REG_ADDR_W +: REG_ADDR_W] = rd_mem[g];
    end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU and buffered LSU results into one registered
// register-file write per cycle and flags pending writes for issue-stage stalls.
module rf_writeback_arbiter import rv_pkg::*; #(
    parameter int XLEN = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_stall,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  pend1,
    output logic                  pend2,
    output logic                  regWen,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [XLEN-1:0]       writeData
);
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0] head_data;
    logic [AW:0] count;
    logic full, empty, push, sel_fifo, sel_alu, hit1, hit2;
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH*REG_ADDR_W-1:0] ent_rd;

    // A full FIFO outranks the ALU so LSU results can never be starved.
    assign sel_fifo = (count == (AW+1)'(DEPTH)) | (!alu_valid & !empty);
    assign sel_alu = alu_valid & !full;
    assign lsu_ready = !Rst & !full;
    assign alu_stall = !Rst & alu_valid & full;
    assign push = lsu_valid & lsu_ready & (lsu_rd != REG_ZERO);

    wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk(Clk),
        .rst(Rst),
        .push(push),
        .push_rd(lsu_rd),
        .push_data(lsu_data),
        .pop(sel_fifo),
        .head_rd(head_rd),
        .head_data(head_data),
        .count(count),
        .full(full),
        .empty(empty),
        .ent_valid(ent_valid),
        .ent_rd(ent_rd)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            regWen <= 1'b0;
            writeReg <= REG_ZERO;
            writeData <= '0;
        end else begin
            regWen <= sel_fifo | (sel_alu & (alu_rd != REG_ZERO));
            if (sel_fifo) begin
                writeReg <= head_rd;
                writeData <= head_data;
            end else if (sel_alu) begin
                writeReg <= alu_rd;
                writeData <= alu_data;
            end
        end
    end

    always_comb begin
        hit1 = regWen & (writeReg == q_rs1);
        hit2 = regWen & (writeReg == q_rs2);
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 | (ent_valid[i] & (ent_rd[i*REG_ADDR_W +: REG_ADDR_W] == q_rs1));
            hit2 = hit2 | (ent_valid[i] & (ent_rd[i*REG_ADDR_W +: REG_ADDR_W] == q_rs2));
        end
    end

    assign pend1 = (q_rs1 != REG_ZERO) & hit1;
    assign pend2 = (q_rs2 != REG_ZERO) & hit2;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed scenarios then random traffic, checked
// against a queue-based model of the writeback rules.
module tb_rf_writeback_arbiter;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_stall;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic        pend1, pend2, regWen;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    ent_t        mq[$];
    logic        m_wen = 1'b0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_data = '0;
    bit          init = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    rf_writeback_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .pend1(pend1), .pend2(pend2),
        .regWen(regWen), .writeReg(writeReg), .writeData(writeData)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend_m(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return m_wen && (m_reg == r);
    endfunction

    task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit   was_full;
        ent_t e;
        @(negedge Clk);
        Rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; q_rs1 = r1; q_rs2 = r2;
        #1;
        was_full = mq.size() == DEPTH;
        chk("lsu_ready", 32'(lsu_ready), 32'(!r && !was_full));
        chk("alu_stall", 32'(alu_stall), 32'(!r && av && was_full));
        if (init) begin
            chk("pend1", 32'(pend1), 32'(pend_m(r1)));
            chk("pend2", 32'(pend2), 32'(pend_m(r2)));
        end
        @(posedge Clk);
        if (r) begin
            mq.delete();
            m_wen = 1'b0; m_reg = '0; m_data = '0; init = 1'b1;
        end else begin
            m_wen = 1'b0;
            if (was_full || (!av && mq.size() > 0)) begin
                e = mq.pop_front();
                m_wen = 1'b1; m_reg = e.rd; m_data = e.data;
            end else if (av && ard != 5'd0) begin
                m_wen = 1'b1; m_reg = ard; m_data = ad;
            end
            if (lv && !was_full && lrd != 5'd0) mq.push_back({lrd, ld});
        end
        #1;
        chk("regWen", 32'(regWen), 32'(m_wen));
        if (m_wen) begin
            chk("writeReg", 32'(writeReg), 32'(m_reg));
            chk("writeData", writeData, m_data);
        end
    endtask

    initial begin
        logic        av, lv, rs;
        logic [4:0]  ard, lrd;
        logic [31:0] ad;
        // reset held with an LSU result offered
        step(1, 0, 0, 0, 1, 4, 32'h44, 0, 0);
        step(1, 0, 0, 0, 1, 4, 32'h44, 0, 0);
        chk("rst_regWen", 32'(regWen), 32'd0);
        chk("rst_writeReg", 32'(writeReg), 32'd0);
        chk("rst_writeData", writeData, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU only, then ALU to x0
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("alu_wen", 32'(regWen), 32'd1);
        chk("alu_wreg", 32'(writeReg), 32'd5);
        chk("alu_wdata", writeData, 32'hDEADBEEF);
        step(0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0);
        chk("alu_x0_wen", 32'(regWen), 32'd0);
        // LSU drain on idle ALU
        step(0, 0, 0, 0, 1, 7, 32'h11, 0, 0);
        step(0, 0, 0, 0, 1, 8, 32'h22, 7, 8);
        step(0, 0, 0, 0, 0, 0, 0, 7, 8);
        step(0, 0, 0, 0, 0, 0, 0, 7, 8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // full FIFO while ALU streams rd=3
        for (int i = 0; i < 6; i++)
            step(0, 1, 3, 32'h300 + i, 1, 5'(10 + i), 32'hA0 + i, 10, 3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 10, 3);
        // hazard on x9 held in the FIFO behind a busy ALU
        step(0, 1, 1, 32'h1, 1, 9, 32'h99, 9, 0);
        step(0, 1, 1, 32'h2, 0, 0, 0, 9, 0);
        chk("haz_pend1", 32'(pend1), 32'd1);
        chk("haz_pend2", 32'(pend2), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("haz_drop", 32'(pend1), 32'd0);
        // mid-operation reset with two queued entries
        step(0, 1, 2, 32'h20, 1, 13, 32'hD, 13, 14);
        step(0, 1, 2, 32'h21, 1, 14, 32'hE, 13, 14);
        step(1, 1, 2, 32'h22, 0, 0, 0, 13, 14);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 13, 14);
        chk("midrst_wen", 32'(regWen), 32'd0);
        // random traffic; stalled ALU results are held stable
        av = 0; ard = 0; ad = 0;
        for (int i = 0; i < 3000; i++) begin
            rs = $urandom_range(0, 99) == 0;
            if (!(av && mq.size() == DEPTH)) begin
                av = $urandom_range(0, 1) == 1;
                ard = 5'($urandom_range(0, 12));
                ad = $urandom;
            end
            lv = $urandom_range(0, 2) != 0;
            lrd = 5'($urandom_range(0, 12));
            step(rs, av, ard, ad, lv, lrd, $urandom,
                 5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
